// File: rtl/t03_spi_master_pkg.sv
// Shared types and defaults for the team 03 SPI master.
//   spi_state_t : transfer sequencer states
//   SPI_WIDTH   : default frame length in bits
//   SPI_DIV_W   : default number of significant clock-divider bits
package t03_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam int SPI_WIDTH = 8;
  localparam int SPI_DIV_W = 16;

endpackage

// File: rtl/t03_spi_master_if.sv
// Bus and pin bundle between the memory-mapped IO block and the SPI master.
//   master modport : the SPI master (consumes start/data/divider and miso,
//                    drives status, received frame and SPI pins)
//   slave modport  : the IO block / pad side
interface t03_spi_master_if;
  import t03_spi_pkg::*;

  logic        tx_start;
  logic [31:0] tx_data;
  logic [31:0] clkdiv;
  logic [31:0] rx_data;
  logic        busy;
  logic        done;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        cs_n;

  modport master (
    input  tx_start, tx_data, clkdiv, miso,
    output rx_data, busy, done, sclk, mosi, cs_n
  );

  modport slave (
    output tx_start, tx_data, clkdiv, miso,
    input  rx_data, busy, done, sclk, mosi, cs_n
  );

endinterface

// File: rtl/t03_spi_master_clkgen.sv
// Half-period timer for the SPI master.
//   clk, nrst   : system clock, async active-low reset
//   load_i      : latch div_i and restart the half period
//   en_i        : count while high
//   div_i       : divider; half period H = div_i + 1 cycles
//   half_tick_o : one-cycle pulse at the end of every half period
module t03_spi_clkgen
  import t03_spi_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             half_tick_o
);

  // One extra bit so that a divider of all ones yields H = 2**DIV_W.
  logic [DIV_W:0] cnt_q, cnt_d;
  logic [DIV_W:0] h_q, h_d;
  logic [DIV_W:0] h_load;

  localparam logic [DIV_W:0] ONE = {{DIV_W{1'b0}}, 1'b1};

  assign h_load      = {1'b0, div_i} + ONE;
  assign half_tick_o = en_i && !load_i && (cnt_q == ONE);

  always_comb begin
    cnt_d = cnt_q;
    h_d   = h_q;
    if (load_i) begin
      cnt_d = h_load;
      h_d   = h_load;
    end else if (en_i) begin
      cnt_d = (cnt_q == ONE) ? h_q : cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= ONE;
      h_q   <= ONE;
    end else begin
      cnt_q <= cnt_d;
      h_q   <= h_d;
    end
  end

endmodule

// File: rtl/t03_spi_master.sv
// SPI mode-0 master for the team 03 IO block.
//   clk, nrst : system clock, async active-low reset
//   bus       : t03_spi_master_if.master -- tx_start/tx_data/clkdiv in,
//               rx_data/busy/done out, sclk/mosi/cs_n out, miso in
// Frames are WIDTH bits, MSB first; received frame is zero-extended.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | cs_n high, sclk low, waiting for tx_start
// SETUP | cs_n low, first bit on mosi, one half period before sclk rises
// SHIFT | sclk toggling; sample miso on rise, advance mosi on fall
// HOLD  | sclk low, cs_n still low for one half period, then done
module t03_spi_master
  import t03_spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH,
  parameter int DIV_W = SPI_DIV_W
) (
  input logic                clk,
  input logic                nrst,
  t03_spi_master_if.master   bus
);

  localparam logic [5:0] LAST_FALL  = 6'(WIDTH);
  localparam logic [5:0] LAST_SHIFT = 6'(WIDTH - 1);

  spi_state_t       state_q, state_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [31:0]      rx_data_q, rx_data_d;
  logic [5:0]       fall_q, fall_d;
  logic             accept;
  logic             half_tick;
  logic             unused_bits;

  // Only the low WIDTH / DIV_W bits of the CPU words matter.
  assign unused_bits = ^{bus.tx_data, bus.clkdiv};

  assign accept = (state_q == IDLE) && bus.tx_start;

  t03_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk         (clk),
    .nrst        (nrst),
    .load_i      (accept),
    .en_i        (state_q != IDLE),
    .div_i       (bus.clkdiv[DIV_W-1:0]),
    .half_tick_o (half_tick)
  );

  always_comb begin
    state_d   = state_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    fall_d    = fall_q;
    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (bus.tx_start) begin
          state_d = SETUP;
          tx_sh_d = bus.tx_data[WIDTH-1:0];
          mosi_d  = bus.tx_data[WIDTH-1];
          rx_sh_d = '0;
          fall_d  = '0;
        end
      end
      SETUP: begin
        if (half_tick) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          rx_sh_d = (rx_sh_q << 1) | WIDTH'(bus.miso);
        end
      end
      SHIFT: begin
        if (half_tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            fall_d = fall_q + 6'd1;
            // After the final fall mosi keeps the last bit through HOLD.
            if (fall_q != LAST_SHIFT) begin
              tx_sh_d = tx_sh_q << 1;
              mosi_d  = tx_sh_d[WIDTH-1];
            end
          end else if (fall_q == LAST_FALL) begin
            // Last low half period has elapsed.
            state_d = HOLD;
          end else begin
            sclk_d  = 1'b1;
            rx_sh_d = (rx_sh_q << 1) | WIDTH'(bus.miso);
          end
        end
      end
      HOLD: begin
        if (half_tick) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = 32'(rx_sh_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      fall_q    <= '0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      fall_q    <= fall_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.cs_n    = (state_q == IDLE);
  assign bus.done    = done_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;

endmodule

// File: tb/tb_t03_spi_master.sv
// Directed bench for t03_spi_master (WIDTH=8, DIV_W=16).
module tb_t03_spi_master;
  import t03_spi_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  logic loop_en;
  logic miso_val;

  always #5 clk = ~clk;

  t03_spi_master_if bus ();

  t03_spi_master #(.WIDTH(8), .DIV_W(16)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always_comb bus.miso = loop_en ? bus.mosi : miso_val;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Per-frame observations.
  int         cs_low, rises, hi_min, hi_max, lo_min, lo_max;
  logic [7:0] mosi_bits;
  logic       got_done;
  logic       first_cs;

  // Call at a negedge. Pulses tx_start, then samples every negedge until done.
  // poke_at: sample index at which a second start (with tx_data=0) is injected.
  // rst_rise: if >0, assert reset right after that many sclk rises and return.
  task automatic do_frame(input logic [31:0] data, input logic [31:0] div,
                          input int budget, input int poke_at, input int rst_rise);
    int   run;
    int   dn;
    logic prev_sclk;
    cs_low = 0; rises = 0; mosi_bits = '0; got_done = 1'b0;
    hi_min = 1 << 30; hi_max = 0; lo_min = 1 << 30; lo_max = 0;
    bus.tx_data  = data;
    bus.clkdiv   = div;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    first_cs  = bus.cs_n;
    prev_sclk = 1'b0;
    run       = 0;
    for (int k = 0; k < budget; k++) begin
      if (k == poke_at) begin
        bus.tx_start = 1'b1;
        bus.tx_data  = 32'h0;
      end
      if (k == poke_at + 1) bus.tx_start = 1'b0;
      if (bus.done) begin
        got_done = 1'b1;
        return;
      end
      if (!bus.cs_n) cs_low++;
      if (bus.sclk != prev_sclk) begin
        if (bus.sclk) begin
          rises++;
          mosi_bits = {mosi_bits[6:0], bus.mosi};
          if (run < lo_min) lo_min = run;
          if (run > lo_max) lo_max = run;
        end else begin
          if (run < hi_min) hi_min = run;
          if (run > hi_max) hi_max = run;
        end
        run = 1;
      end else if (!bus.cs_n) begin
        run++;
      end
      prev_sclk = bus.sclk;
      if (rst_rise > 0 && rises == rst_rise) begin
        #1 nrst = 1'b0;
        #1;
        check("rst_cs_n", bus.cs_n, 1);
        check("rst_sclk", bus.sclk, 0);
        check("rst_mosi", bus.mosi, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rx_data", bus.rx_data, 0);
        dn = 0;
        repeat (4) begin
          @(negedge clk);
          if (bus.done) dn++;
        end
        nrst = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if (bus.done) dn++;
        end
        check("rst_no_done", dn, 0);
        return;
      end
      @(negedge clk);
    end
    check("frame_timeout", got_done, 1);
  endtask

  initial begin
    int cnt;
    nrst         = 1'b0;
    loop_en      = 1'b1;
    miso_val     = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_data  = '0;
    bus.clkdiv   = '0;
    repeat (3) @(negedge clk);
    check("reset_cs_n", bus.cs_n, 1);
    check("reset_sclk", bus.sclk, 0);
    check("reset_mosi", bus.mosi, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_rx_data", bus.rx_data, 0);
    nrst = 1'b1;
    @(negedge clk);

    // Loopback, H=1.
    do_frame(32'hA5, 32'h0, 200, -1, 0);
    check("lb_first_cs", first_cs, 0);
    check("lb_done", bus.done, 1);
    check("lb_rx_data", bus.rx_data, 32'h0000_00A5);
    check("lb_cs_low", cs_low, 18);
    check("lb_rises", rises, 8);
    check("lb_hi_min", hi_min, 1);
    check("lb_hi_max", hi_max, 1);
    check("lb_lo_min", lo_min, 1);
    check("lb_lo_max", lo_max, 1);
    check("lb_mosi_bits", mosi_bits, 8'hA5);
    @(negedge clk);
    check("lb_done_width", bus.done, 0);
    check("lb_idle_busy", bus.busy, 0);
    check("lb_idle_mosi", bus.mosi, 0);

    // Divider 3 -> H=4, miso held high.
    loop_en  = 1'b0;
    miso_val = 1'b1;
    @(negedge clk);
    do_frame(32'h3C, 32'h3, 400, -1, 0);
    check("div_rx_data", bus.rx_data, 32'h0000_00FF);
    check("div_cs_low", cs_low, 72);
    check("div_rises", rises, 8);
    check("div_hi_min", hi_min, 4);
    check("div_hi_max", hi_max, 4);
    check("div_lo_min", lo_min, 4);
    check("div_lo_max", lo_max, 4);
    check("div_mosi_bits", mosi_bits, 8'h3C);
    @(negedge clk);
    check("div_done_width", bus.done, 0);

    // Start while busy, tx_data cleared mid-frame.
    loop_en = 1'b1;
    @(negedge clk);
    do_frame(32'hA5, 32'h0, 200, 5, 0);
    check("busy_rx_data", bus.rx_data, 32'h0000_00A5);
    check("busy_mosi_bits", mosi_bits, 8'hA5);
    check("busy_rises", rises, 8);
    check("busy_cs_low", cs_low, 18);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done || bus.busy || !bus.cs_n) cnt++;
    end
    check("busy_no_second_frame", cnt, 0);

    // Back-to-back: restart in the done cycle.
    @(negedge clk);
    do_frame(32'h3C, 32'h0, 200, -1, 0);
    check("b2b_rx1", bus.rx_data, 32'h0000_003C);
    check("b2b_gap_high", bus.cs_n, 1);
    do_frame(32'hC3, 32'h0, 200, -1, 0);
    check("b2b_gap_one_cycle", first_cs, 0);
    check("b2b_cs_low", cs_low, 18);
    check("b2b_rx2", bus.rx_data, 32'h0000_00C3);
    check("b2b_mosi_bits", mosi_bits, 8'hC3);

    // Reset after the 3rd rising edge, then a clean frame.
    @(negedge clk);
    do_frame(32'hA5, 32'h0, 200, -1, 3);
    check("rst_got_done", got_done, 0);
    @(negedge clk);
    do_frame(32'h5A, 32'h0, 200, -1, 0);
    check("rst_after_rx", bus.rx_data, 32'h0000_005A);
    check("rst_after_cs_low", cs_low, 18);

    // Max divider: SETUP must last 65536 cycles before the first rise.
    @(negedge clk);
    bus.clkdiv   = 32'hFFFF_FFFF;
    bus.tx_data  = 32'hA5;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    cnt = 0;
    while (bus.sclk == 1'b0 && cnt < 70000) begin
      cnt++;
      @(negedge clk);
    end
    check("maxdiv_setup_len", cnt, 65536);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.sclk) cnt++;
    end
    check("maxdiv_high_holds", cnt, 10);
    nrst = 1'b0;
    #1;
    check("maxdiv_abort_cs_n", bus.cs_n, 1);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
